coin_input_conditioner: RTL

COIN_INPUT_CONDITIONER -- requirements
Module: coin_input_conditioner

---
 rtl/coin_input_conditioner.sv | 123 ++++++++++++
 1 files changed

// File: rtl/coin_input_conditioner.sv
// Coin/button conditioner: 2-flop sync, per-channel debounce, rising-edge events arbitrated
// into one-hot single-cycle pulses. Define COIN_TALLY_EN to add the running cents tally.
module coin_input_conditioner #(
  parameter int unsigned DEB_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       quarter_raw,
  input  logic       dime_raw,
  input  logic       nickel_raw,
  input  logic       soda_raw,
  input  logic       diet_raw,
  output logic       quarter,
  output logic       dime,
  output logic       nickel,
  output logic       soda,
  output logic       diet,
  output logic       drop_err
`ifdef COIN_TALLY_EN
  ,
  input  logic       tally_clr,
  output logic [7:0] tally
`endif
);

  localparam int unsigned NumCh  = 5;
  localparam logic [3:0]  CntMax = 4'(DEB_CYCLES - 1);

  // Bit order is priority order: 0 = quarter (highest) .. 4 = diet (lowest).
  logic [NumCh-1:0] raw;
  logic [NumCh-1:0] sync1_q, sync2_q;
  logic [NumCh-1:0] deb_q, deb_d, deb_prev_q;
  logic [NumCh-1:0] pend_q, pend_d;
  logic [NumCh-1:0] rise, grant, out_q;
  logic [3:0]       cnt_q [NumCh];
  logic [3:0]       cnt_d [NumCh];
  logic             drop;
  logic             drop_err_q;

  assign raw = {diet_raw, soda_raw, nickel_raw, dime_raw, quarter_raw};

  always_comb begin
    for (int i = 0; i < NumCh; i++) begin
      cnt_d[i] = '0;
      deb_d[i] = deb_q[i];
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CntMax) begin
          deb_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 4'd1;
        end
      end
    end
  end

  assign rise   = deb_q & ~deb_prev_q;
  // Isolate the lowest set bit: the highest-priority pending event.
  assign grant  = pend_q & (~pend_q + NumCh'(1));
  assign pend_d = (pend_q & ~grant) | rise;
  assign drop   = |(rise & pend_q & ~grant);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      pend_q     <= '0;
      out_q      <= '0;
      drop_err_q <= 1'b0;
      for (int i = 0; i < NumCh; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q    <= raw;
      sync2_q    <= sync1_q;
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      pend_q     <= pend_d;
      out_q      <= grant;
      drop_err_q <= drop_err_q | drop;
      for (int i = 0; i < NumCh; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign quarter  = out_q[0];
  assign dime     = out_q[1];
  assign nickel   = out_q[2];
  assign soda     = out_q[3];
  assign diet     = out_q[4];
  assign drop_err = drop_err_q;

`ifdef COIN_TALLY_EN
  logic [7:0] tally_q;
  logic [7:0] coin_val;

  always_comb begin
    coin_val = 8'd0;
    if (out_q[0]) begin
      coin_val = 8'd25;
    end else if (out_q[1]) begin
      coin_val = 8'd10;
    end else if (out_q[2]) begin
      coin_val = 8'd5;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tally_q <= 8'd0;
    end else if (tally_clr) begin
      tally_q <= 8'd0;
    end else begin
      tally_q <= tally_q + coin_val;
    end
  end

  assign tally = tally_q;
`endif

endmodule
